pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It watches the ID-stage source registers, the EX and MEM destination/write-back controls, the EX branch decision and the MEM-stage memory access. It drives the load and clear inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It contains a multi-cycle memory-wait state machine that freezes the pipeline while a slow data memory completes an access.

---
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline, with a memory-wait FSM for slow data memory.
// Hazard and branch controls are combinational; an access of MEM_LAT cycles freezes the pipe for MEM_LAT-1 cycles.
module pipeline_ctrl #(
    parameter int MEM_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] idSrc1,
    input  logic [3:0] idSrc2,
    input  logic       idTwoSrc,
    input  logic       idSrc1Valid,
    input  logic [3:0] exeDest,
    input  logic       exeWbEn,
    input  logic       exeMemRead,
    input  logic [3:0] memDest,
    input  logic       memWbEn,
    input  logic       fwdEn,
    input  logic       branchTaken,
    input  logic       memAccess,
    output logic       pcLd,
    output logic       ifIdLd,
    output logic       ifIdFlush,
    output logic       idExLd,
    output logic       idExFlush,
    output logic       exMemLd,
    output logic       memWbClr,
    output logic       memBusy,
    output logic       hazard
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic       MULTI_CYC  = (MEM_LAT > 1);
    localparam logic [1:0] FIRST_NEXT = (MEM_LAT > 2) ? BUSY : DONE;
    // Only meaningful when MEM_LAT > 2; BUSY is unreachable otherwise.
    localparam logic [3:0] LAST_CNT   = 4'(MEM_LAT - 2);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       stall_raw;
    logic       stall;
    logic       hit_exe, hit_mem;

    assign hit_exe = (idSrc1Valid & (idSrc1 == exeDest)) | (idTwoSrc & (idSrc2 == exeDest));
    assign hit_mem = (idSrc1Valid & (idSrc1 == memDest)) | (idTwoSrc & (idSrc2 == memDest));

    always_comb begin
        if (fwdEn) begin
            hazard = exeWbEn & exeMemRead & hit_exe;
        end else begin
            hazard = (exeWbEn & hit_exe) | (memWbEn & hit_mem);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (memAccess && MULTI_CYC) begin
                    stall_raw = 1'b1;
                    cnt_d     = 4'd1;
                    state_d   = FIRST_NEXT;
                end
            end
            BUSY: begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            // DONE lets the finished access advance without re-triggering on its own memAccess.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall   = stall_raw & ~rst;
    assign memBusy = stall;

    always_comb begin
        pcLd      = 1'b1;
        ifIdLd    = 1'b1;
        ifIdFlush = 1'b0;
        idExLd    = 1'b1;
        idExFlush = 1'b0;
        exMemLd   = 1'b1;
        memWbClr  = 1'b0;
        if (rst) begin
            pcLd = 1'b1;
        end else if (stall) begin
            pcLd     = 1'b0;
            ifIdLd   = 1'b0;
            idExLd   = 1'b0;
            exMemLd  = 1'b0;
            memWbClr = 1'b1;
        end else if (branchTaken) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else if (hazard) begin
            pcLd      = 1'b0;
            ifIdLd    = 1'b0;
            idExFlush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: three instances (MEM_LAT 4, 3, 1) share one set of inputs.
// Output vector order: pcLd ifIdLd ifIdFlush idExLd idExFlush exMemLd memWbClr memBusy hazard.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] idSrc1 = 4'd0, idSrc2 = 4'd0, exeDest = 4'd0, memDest = 4'd0;
    logic       idTwoSrc = 1'b0, idSrc1Valid = 1'b0, exeWbEn = 1'b0, exeMemRead = 1'b0;
    logic       memWbEn = 1'b0, fwdEn = 1'b0, branchTaken = 1'b0, memAccess = 1'b0;
    logic [8:0] oa, ob, oc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_LAT(4)) u_a (
        .clk(clk), .rst(rst), .idSrc1(idSrc1), .idSrc2(idSrc2), .idTwoSrc(idTwoSrc),
        .idSrc1Valid(idSrc1Valid), .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemRead(exeMemRead),
        .memDest(memDest), .memWbEn(memWbEn), .fwdEn(fwdEn), .branchTaken(branchTaken),
        .memAccess(memAccess), .pcLd(oa[8]), .ifIdLd(oa[7]), .ifIdFlush(oa[6]), .idExLd(oa[5]),
        .idExFlush(oa[4]), .exMemLd(oa[3]), .memWbClr(oa[2]), .memBusy(oa[1]), .hazard(oa[0])
    );

    pipeline_ctrl #(.MEM_LAT(3)) u_b (
        .clk(clk), .rst(rst), .idSrc1(idSrc1), .idSrc2(idSrc2), .idTwoSrc(idTwoSrc),
        .idSrc1Valid(idSrc1Valid), .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemRead(exeMemRead),
        .memDest(memDest), .memWbEn(memWbEn), .fwdEn(fwdEn), .branchTaken(branchTaken),
        .memAccess(memAccess), .pcLd(ob[8]), .ifIdLd(ob[7]), .ifIdFlush(ob[6]), .idExLd(ob[5]),
        .idExFlush(ob[4]), .exMemLd(ob[3]), .memWbClr(ob[2]), .memBusy(ob[1]), .hazard(ob[0])
    );

    pipeline_ctrl #(.MEM_LAT(1)) u_c (
        .clk(clk), .rst(rst), .idSrc1(idSrc1), .idSrc2(idSrc2), .idTwoSrc(idTwoSrc),
        .idSrc1Valid(idSrc1Valid), .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemRead(exeMemRead),
        .memDest(memDest), .memWbEn(memWbEn), .fwdEn(fwdEn), .branchTaken(branchTaken),
        .memAccess(memAccess), .pcLd(oc[8]), .ifIdLd(oc[7]), .ifIdFlush(oc[6]), .idExLd(oc[5]),
        .idExFlush(oc[4]), .exMemLd(oc[3]), .memWbClr(oc[2]), .memBusy(oc[1]), .hazard(oc[0])
    );

    // Expected control patterns (upper 8 bits), hazard appended by the caller.
    localparam logic [7:0] V_DEF = 8'b1101_0100;
    localparam logic [7:0] V_STL = 8'b0000_0011;
    localparam logic [7:0] V_BR  = 8'b1111_1100;
    localparam logic [7:0] V_HZ  = 8'b0001_1100;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and checks happen here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b1;
        #3;
        check("rst_a", oa, {V_DEF, 1'b0});
        memAccess = 1'b1;
        #1;
        check("rst_memacc_a", oa, {V_DEF, 1'b0});
        check("rst_memacc_b", ob, {V_DEF, 1'b0});
        memAccess = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_a", oa, {V_DEF, 1'b0});

        // MEM_LAT=4 single access: three stall cycles then DONE; MEM_LAT=1 never stalls.
        memAccess = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("lat4_c%0d", i), oa, (i < 3) ? {V_STL, 1'b0} : {V_DEF, 1'b0});
            check($sformatf("lat1_c%0d", i), oc, {V_DEF, 1'b0});
            tick();
        end
        memAccess = 1'b0;
        #1;
        check("lat4_after", oa, {V_DEF, 1'b0});
        for (int i = 0; i < 5; i++) tick();

        // MEM_LAT=3 back-to-back loads: busy 1,1,0,1,1,0.
        memAccess = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("lat3_c%0d", i), ob, (i % 3 != 2) ? {V_STL, 1'b0} : {V_DEF, 1'b0});
            tick();
        end
        memAccess = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("quiet_a", oa, {V_DEF, 1'b0});
        check("quiet_b", ob, {V_DEF, 1'b0});

        // Non-forwarding hazards.
        fwdEn = 1'b0; idSrc1 = 4'd5; idSrc1Valid = 1'b1; memDest = 4'd5; memWbEn = 1'b1;
        #1;
        check("nofwd_mem_hz", oa, {V_HZ, 1'b1});
        memWbEn = 1'b0;
        #1;
        check("nofwd_mem_off", oa, {V_DEF, 1'b0});
        exeDest = 4'd5; exeWbEn = 1'b1;
        #1;
        check("nofwd_exe_hz", oa, {V_HZ, 1'b1});
        idSrc1Valid = 1'b0;
        #1;
        check("nofwd_src1_invalid", oa, {V_DEF, 1'b0});

        // Forwarding: only load-use on EX hazards.
        fwdEn = 1'b1; idTwoSrc = 1'b1; idSrc2 = 4'd3; exeDest = 4'd3; exeWbEn = 1'b1; exeMemRead = 1'b0;
        #1;
        check("fwd_no_load", oa, {V_DEF, 1'b0});
        exeMemRead = 1'b1;
        #1;
        check("fwd_load_use", oa, {V_HZ, 1'b1});
        exeMemRead = 1'b0; memDest = 4'd3; memWbEn = 1'b1;
        #1;
        check("fwd_mem_ignored", oa, {V_DEF, 1'b0});
        memWbEn = 1'b0; exeMemRead = 1'b1;

        // Branch beats hazard.
        branchTaken = 1'b1;
        #1;
        check("branch_over_hz", oa, {V_BR, 1'b1});
        exeMemRead = 1'b0;
        tick();

        // Branch held during a stall: frozen, then flushes once the wait ends.
        memAccess = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("br_stall_c%0d", i), oa, (i < 3) ? {V_STL, 1'b0} : {V_BR, 1'b0});
            tick();
        end
        memAccess = 1'b0; branchTaken = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Reset during BUSY abandons the wait; a fresh full stall follows.
        memAccess = 1'b1;
        tick();
        #1;
        check("pre_rst_busy", oa, {V_STL, 1'b0});
        rst = 1'b1;
        #1;
        check("rst_mid_busy", oa, {V_DEF, 1'b0});
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("post_rst_c%0d", i), oa, (i < 3) ? {V_STL, 1'b0} : {V_DEF, 1'b0});
            tick();
        end
        memAccess = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, required finish before 50000");
        $fatal(1);
    end

endmodule
